cache_mem_arbiter: RTL and testbench

- Arbitrates the single main-memory port between the instruction cache refill path and the data cache refill/writeback path.
- Sits between the IR_ID instruction cache and the WB_Data_WB data cache on one side, and main memory on the other.
- Runs one line-sized burst at a time. Priority goes to the data cache, with a starvation guard for the instruction cache.
- Produces the per-beat handshakes and the end-of-line done pulses that the caches' miss FSMs wait on.

---
 rtl/cache_mem_arbiter_if.sv | 36 +++
 rtl/cache_mem_arbiter.sv | 89 ++++++++
 tb/tb_cache_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: I-cache, D-cache and main-memory signals of the line arbiter.
interface cache_mem_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        ic_done;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_wready;
    logic [31:0] dc_rdata;
    logic        dc_rvalid;
    logic        dc_done;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  owner;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
        output ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
               mem_valid, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
        input  ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
               mem_valid, mem_we, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: one line burst at a time to main memory, D-cache first with an I-cache starvation guard.
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int MAX_WAIT   = 4
) (
    input logic                clk,
    input logic                rst_n,
    cache_mem_arbiter_if.slave bus
);
    localparam int BW = $clog2(LINE_WORDS);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [31:0]    base_q, base_d;
    logic           we_q, we_d;
    logic [1:0]     owner_q, owner_d;
    logic           gnt_i, gnt_d, in_burst, beat_ok;

    assign gnt_i = bus.ic_req & (~bus.dc_req | (starve_q == SW'(MAX_WAIT)));
    assign gnt_d = bus.dc_req & ~gnt_i;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        base_d   = base_q;
        we_d     = we_q;
        owner_d  = owner_q;
        case (state_q)
            IDLE: if (gnt_i | gnt_d) begin
                state_d  = BURST;
                beat_d   = '0;
                base_d   = (gnt_i ? bus.ic_addr : bus.dc_addr) & LINE_MASK;
                we_d     = gnt_d & bus.dc_we;
                owner_d  = {gnt_d, gnt_i};
                starve_d = gnt_i ? '0 : (bus.ic_req && starve_q != SW'(MAX_WAIT)) ? starve_q + 1'b1 : starve_q;
            end
            BURST: if (bus.mem_ready) begin
                beat_d  = beat_q + 1'b1;
                state_d = (beat_q == BW'(LINE_WORDS - 1)) ? DONE : BURST;
            end
            DONE: begin
                state_d = IDLE;
                owner_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            starve_q <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            base_q   <= base_d;
            we_q     <= we_d;
            owner_q  <= owner_d;
        end
    end

    // Beat handshakes are combinational on mem_ready so a cache sees data in the same cycle.
    assign in_burst      = state_q == BURST;
    assign beat_ok       = in_burst & bus.mem_ready;
    assign bus.mem_valid = in_burst;
    assign bus.mem_we    = in_burst & we_q;
    assign bus.mem_addr  = in_burst ? base_q + {{(30 - BW){1'b0}}, beat_q, 2'b00} : '0;
    assign bus.mem_wdata = bus.mem_we ? bus.dc_wdata : '0;
    assign bus.ic_rvalid = beat_ok & ~we_q & owner_q[0];
    assign bus.dc_rvalid = beat_ok & ~we_q & owner_q[1];
    assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
    assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;
    assign bus.dc_wready = beat_ok & we_q;
    assign bus.ic_done   = (state_q == DONE) & owner_q[0];
    assign bus.dc_done   = (state_q == DONE) & owner_q[1];
    assign bus.busy      = state_q != IDLE;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed vector table, hand sequences and random traffic checked
// against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;
    localparam int LW = 8;
    localparam int MW = 2;
    localparam logic [31:0] LMASK = ~(32'(LW * 4) - 32'd1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();
    cache_mem_arbiter #(.LINE_WORDS(LW), .MAX_WAIT(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          owner;
        logic [31:0] base;
    } grant_t;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        int          mode;
        int          n;
        int          o0;
        logic [31:0] b0;
        int          o1;
        logic [31:0] b1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model: current line owner (0 none, 1 I, 2 D), its base, direction, beats done and left.
    int          m_owner, m_beat, m_left, m_starve;
    logic [31:0] m_base;
    logic        m_we;
    grant_t      glog[$];

    int   mode;
    logic tgl;
    bit   ic_keep, dc_keep;
    int   n_busy, n_beats, n_wr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit burst, done, rd;
        burst = m_owner != 0 && m_left > 0;
        done  = m_owner != 0 && m_left == 0;
        rd    = burst && bus.mem_ready && !m_we;
        chk("mem_valid", 32'(bus.mem_valid), 32'(burst));
        chk("mem_we", 32'(bus.mem_we), 32'(burst && m_we));
        if (burst) chk("mem_addr", bus.mem_addr, m_base + 32'(4 * m_beat));
        if (burst && m_we) chk("mem_wdata", bus.mem_wdata, bus.dc_wdata);
        chk("ic_rvalid", 32'(bus.ic_rvalid), 32'(rd && m_owner == 1));
        chk("dc_rvalid", 32'(bus.dc_rvalid), 32'(rd && m_owner == 2));
        if (rd && m_owner == 1) chk("ic_rdata", bus.ic_rdata, bus.mem_rdata);
        if (rd && m_owner == 2) chk("dc_rdata", bus.dc_rdata, bus.mem_rdata);
        chk("dc_wready", 32'(bus.dc_wready), 32'(burst && bus.mem_ready && m_we));
        chk("ic_done", 32'(bus.ic_done), 32'(done && m_owner == 1));
        chk("dc_done", 32'(bus.dc_done), 32'(done && m_owner == 2));
        chk("busy", 32'(bus.busy), 32'(m_owner != 0));
        chk("owner", 32'(bus.owner), 32'(m_owner));
        n_busy += int'(bus.busy);
        n_wr += int'(bus.dc_wready);
        if (bus.mem_valid && bus.mem_ready) n_beats++;
    endtask

    task automatic model_step(output bit di, output bit dd);
        bit gi, gd;
        di = 1'b0;
        dd = 1'b0;
        if (m_owner == 0) begin
            gi = bus.ic_req && (!bus.dc_req || m_starve == MW);
            gd = bus.dc_req && !gi;
            if (gi || gd) begin
                m_owner = gi ? 1 : 2;
                m_base  = (gi ? bus.ic_addr : bus.dc_addr) & LMASK;
                m_we    = gd && bus.dc_we;
                m_beat  = 0;
                m_left  = LW;
                glog.push_back('{m_owner, m_base});
            end
            if (gi) m_starve = 0;
            else if (gd && bus.ic_req && m_starve < MW) m_starve++;
        end else if (m_left > 0) begin
            if (bus.mem_ready) begin
                m_beat++;
                m_left--;
            end
        end else begin
            di = m_owner == 1;
            dd = m_owner == 2;
            m_owner = 0;
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle();
        bit di, dd;
        bus.mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tgl : 1'($urandom_range(0, 1));
        tgl = ~tgl;
        bus.mem_rdata = $urandom;
        bus.dc_wdata  = $urandom;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step(di, dd);
        #1;
        if (di && !ic_keep) bus.ic_req = 1'b0;
        if (dd && !dc_keep) bus.dc_req = 1'b0;
    endtask

    task automatic run_until_quiet(int maxc);
        int n;
        n = 0;
        while ((bus.ic_req || bus.dc_req || m_owner != 0) && n < maxc) begin
            cycle();
            n++;
        end
        if (bus.ic_req || bus.dc_req || m_owner != 0) begin
            checks++;
            errors++;
            $display("FAIL quiet_timeout: still active after %0d cycles", maxc);
        end
    endtask

    task automatic zero_check(string tag);
        chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_ic_rvalid"}, 32'(bus.ic_rvalid), 0);
        chk({tag, "_dc_rvalid"}, 32'(bus.dc_rvalid), 0);
        chk({tag, "_ic_rdata"}, bus.ic_rdata, 0);
        chk({tag, "_dc_rdata"}, bus.dc_rdata, 0);
        chk({tag, "_dc_wready"}, 32'(bus.dc_wready), 0);
        chk({tag, "_ic_done"}, 32'(bus.ic_done), 0);
        chk({tag, "_dc_done"}, 32'(bus.dc_done), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_owner"}, 32'(bus.owner), 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        ic_keep = 1'b0;
        dc_keep = 1'b0;
        #1;
        zero_check("rst");
        m_owner = 0; m_beat = 0; m_left = 0; m_starve = 0; m_base = '0; m_we = 1'b0;
        repeat (2) begin
            @(negedge clk);
            zero_check("rst_hold");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tab[6];
    int   exp_ord[6];

    initial begin
        tab[0] = '{1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0, 0, 1, 1, 32'h0000_1000, 0, 32'h0};
        tab[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 0, 1, 2, 32'h0000_2000, 0, 32'h0};
        tab[2] = '{1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_2000, 0, 2, 2, 32'h0000_2000, 1, 32'h0000_3000};
        tab[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_4010, 1, 1, 2, 32'h0000_4000, 0, 32'h0};
        tab[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFE4, 0, 1, 2, 32'hFFFF_FFE0, 0, 32'h0};
        tab[5] = '{1'b1, 32'h0000_5038, 1'b1, 1'b1, 32'h0000_6044, 2, 2, 2, 32'h0000_6040, 1, 32'h0000_5020};
        exp_ord = '{2, 2, 1, 2, 2, 1};

        bus.ic_req = 1'b0; bus.ic_addr = '0; bus.dc_req = 1'b0; bus.dc_we = 1'b0;
        bus.dc_addr = '0; bus.dc_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        mode = 0;
        tgl = 1'b1;
        #1;
        apply_reset();

        for (int i = 0; i < 6; i++) begin
            glog.delete();
            n_busy = 0; n_beats = 0; n_wr = 0;
            mode = tab[i].mode;
            tgl = 1'b1;
            bus.ic_req = tab[i].ir; bus.ic_addr = tab[i].ia;
            bus.dc_req = tab[i].dr; bus.dc_we = tab[i].dwe; bus.dc_addr = tab[i].da;
            run_until_quiet(300);
            chk($sformatf("v%0d_grants", i), glog.size(), tab[i].n);
            if (glog.size() >= 1) begin
                chk($sformatf("v%0d_owner0", i), glog[0].owner, tab[i].o0);
                chk($sformatf("v%0d_base0", i), glog[0].base, tab[i].b0);
            end
            if (tab[i].n == 2 && glog.size() >= 2) begin
                chk($sformatf("v%0d_owner1", i), glog[1].owner, tab[i].o1);
                chk($sformatf("v%0d_base1", i), glog[1].base, tab[i].b1);
            end
            chk($sformatf("v%0d_beats", i), n_beats, tab[i].n * LW);
            chk($sformatf("v%0d_wready", i), n_wr, tab[i].dwe ? LW : 0);
            if (tab[i].mode == 0) chk($sformatf("v%0d_busy_cycles", i), n_busy, tab[i].n * (LW + 1));
        end

        // Starvation guard: both requesters never let go.
        apply_reset();
        glog.delete();
        mode = 0;
        ic_keep = 1'b1; dc_keep = 1'b1;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_7000;
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h0000_8000;
        for (int n = 0; n < 300 && glog.size() < 6; n++) cycle();
        chk("starve_grants", glog.size(), 6);
        if (glog.size() >= 6)
            for (int k = 0; k < 6; k++) chk($sformatf("starve_order%0d", k), glog[k].owner, exp_ord[k]);
        ic_keep = 1'b0; dc_keep = 1'b0;
        run_until_quiet(300);

        // Reset during beat 3 of an I refill, then a fresh line.
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1000; mode = 0;
        for (int n = 0; n < 20 && !(m_owner == 1 && m_beat == 3); n++) cycle();
        chk("abort_at_beat3", 32'(m_owner == 1 && m_beat == 3), 1);
        apply_reset();
        glog.delete();
        n_beats = 0;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1000;
        run_until_quiet(100);
        chk("post_rst_grants", glog.size(), 1);
        if (glog.size() >= 1) chk("post_rst_base", glog[0].base, 32'h0000_1000);
        chk("post_rst_beats", n_beats, LW);

        // Random traffic with random memory stalls and addresses moving under a held request.
        mode = 2;
        for (int n = 0; n < 600; n++) begin
            if (!bus.ic_req && $urandom_range(0, 2) == 0) bus.ic_req = 1'b1;
            if (!bus.dc_req && $urandom_range(0, 2) == 0) bus.dc_req = 1'b1;
            bus.ic_addr = $urandom;
            bus.dc_addr = $urandom;
            bus.dc_we = 1'($urandom_range(0, 1));
            cycle();
        end
        run_until_quiet(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
